eq_band_scheduler: RTL and testbench

Sequences the equalizer's single shared multiply-accumulate datapath across all 8 filter bands for each incoming audio sample. On each new-sample strobe it walks band_sel 0..NUM_BANDS-1. For each band it issues a MAC clear, sweeps the coefficient/tap address 0..NUM_TAPS-1, then flags the band result as ready. It sits between the sample-rate strobe generator and the coefficient ROMs, delay line and MAC, and replaces free-running tap counting with frame-aware control.

---
 rtl/eq_band_scheduler_if.sv | 27 ++
 rtl/eq_band_scheduler.sv | 108 ++++++++++
 tb/tb_eq_band_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/eq_band_scheduler_if.sv
// Control bundle between the sample strobe source and the shared-MAC band scheduler.
// The master modport drives the strobes. The slave modport is the scheduler side.
interface eq_band_scheduler_if #(
   parameter int BAND_W = 3,
   parameter int TAP_W  = 6
);
   logic              clk_enable;
   logic              sample_valid;
   logic              busy;
   logic [BAND_W-1:0] band_sel;
   logic [TAP_W-1:0]  tap_addr;
   logic              mac_clear;
   logic              mac_en;
   logic              band_done;
   logic              frame_done;
   logic              overrun;

   modport master (
      output clk_enable, sample_valid,
      input  busy, band_sel, tap_addr, mac_clear, mac_en, band_done, frame_done, overrun
   );

   modport slave (
      input  clk_enable, sample_valid,
      output busy, band_sel, tap_addr, mac_clear, mac_en, band_done, frame_done, overrun
   );
endinterface

// File: rtl/eq_band_scheduler.sv
// Frame-aware sequencer for the equalizer's shared MAC: for each sample it runs
// clear / tap sweep / flush for every band, then signals frame completion.
module eq_band_scheduler #(
   parameter int NUM_BANDS = 8,
   parameter int NUM_TAPS  = 64,
   parameter int TAP_W     = 6,
   parameter int BAND_W    = 3
) (
   input logic               clk,
   input logic               rst,
   eq_band_scheduler_if.slave bus
);
   localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(NUM_TAPS - 1);
   localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DONE} state_t;

   state_t            state;
   logic              busy;
   logic [BAND_W-1:0] band_sel;
   logic [TAP_W-1:0]  tap_addr;
   logic              mac_clear;
   logic              mac_en;
   logic              band_done;
   logic              frame_done;
   logic              overrun;

   // Outputs are written on the transition into each state, so they always
   // match the state register without any decode after the flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         band_sel   <= '0;
         tap_addr   <= '0;
         mac_clear  <= 1'b0;
         mac_en     <= 1'b0;
         band_done  <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else if (bus.clk_enable) begin
         overrun <= bus.sample_valid && (state != IDLE);
         case (state)
            IDLE: begin
               if (bus.sample_valid) begin
                  state     <= CLEAR;
                  busy      <= 1'b1;
                  band_sel  <= '0;
                  tap_addr  <= '0;
                  mac_clear <= 1'b1;
               end
            end
            CLEAR: begin
               state     <= RUN;
               tap_addr  <= '0;
               mac_clear <= 1'b0;
               mac_en    <= 1'b1;
            end
            RUN: begin
               if (tap_addr == LAST_TAP) begin
                  state     <= FLUSH;
                  tap_addr  <= '0;
                  mac_en    <= 1'b0;
                  band_done <= 1'b1;
               end else begin
                  tap_addr <= tap_addr + 1'b1;
               end
            end
            FLUSH: begin
               band_done <= 1'b0;
               if (band_sel == LAST_BAND) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end else begin
                  state     <= CLEAR;
                  band_sel  <= band_sel + 1'b1;
                  mac_clear <= 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               busy       <= 1'b0;
               band_sel   <= '0;
               frame_done <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               band_sel   <= '0;
               tap_addr   <= '0;
               mac_clear  <= 1'b0;
               mac_en     <= 1'b0;
               band_done  <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = busy;
   assign bus.band_sel   = band_sel;
   assign bus.tap_addr   = tap_addr;
   assign bus.mac_clear  = mac_clear;
   assign bus.mac_en     = mac_en;
   assign bus.band_done  = band_done;
   assign bus.frame_done = frame_done;
   assign bus.overrun    = overrun;
endmodule

// File: tb/tb_eq_band_scheduler.sv
// Directed bench for eq_band_scheduler: reset, full frames, enable gating,
// overrun, mid-frame reset and back-to-back frames.
module tb_eq_band_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;

   int tests = 0;
   int fails = 0;
   int band_total = 0;

   eq_band_scheduler_if #(.BAND_W(3), .TAP_W(6)) bus ();

   eq_band_scheduler #(
      .NUM_BANDS(8),
      .NUM_TAPS (64),
      .TAP_W    (6),
      .BAND_W   (3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [13:0] obs;
   assign obs = {bus.busy, bus.band_sel, bus.tap_addr,
                 bus.mac_clear, bus.mac_en, bus.band_done, bus.frame_done};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {busy, band_sel, tap_addr, clear, en, band_done, frame_done}
   // after the k-th enabled edge counted from the capture edge (k=1).
   function automatic logic [13:0] model(input int k);
      int b;
      int p;
      logic [2:0] bs;
      logic [5:0] ta;
      logic [3:0] pl;
      if (k < 1 || k > 529) return '0;
      if (k == 529) return {1'b1, 3'd7, 6'd0, 4'b0001};
      b  = (k - 1) / 66;
      p  = (k - 1) % 66;
      bs = 3'(b);
      if (p == 0) begin
         ta = 6'd0;  pl = 4'b1000;
      end else if (p <= 64) begin
         ta = 6'(p - 1); pl = 4'b0100;
      end else begin
         ta = 6'd0;  pl = 4'b0010;
      end
      return {1'b1, bs, ta, pl};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Captures a sample, then checks every enabled edge up to last_k. With gate
   // set, a disabled edge precedes each enabled one and must hold everything.
   // ovr_k: enabled edge that sees a second sample_valid (0 = none).
   task automatic run_frame(input bit gate, input int ovr_k, input int last_k);
      int bd_cnt;
      bit exp_ovr;
      bit prev_ovr;
      bd_cnt   = 0;
      prev_ovr = 1'b0;
      if (gate) begin
         bus.clk_enable   = 1'b0;
         bus.sample_valid = 1'b1;
         step();
         check("gated_capture", 32'(obs), 32'd0);
      end
      bus.clk_enable   = 1'b1;
      bus.sample_valid = 1'b1;
      step();
      bus.sample_valid = 1'b0;
      for (int k = 1; k <= last_k; k++) begin
         if (k > 1) begin
            if (gate) begin
               bus.clk_enable = 1'b0;
               step();
               check($sformatf("hold_k%0d", k - 1), 32'(obs), 32'(model(k - 1)));
               check($sformatf("hold_ovr_k%0d", k - 1), 32'(bus.overrun), 32'(prev_ovr));
               bus.clk_enable = 1'b1;
            end
            bus.sample_valid = (k == ovr_k);
            step();
            bus.sample_valid = 1'b0;
         end
         exp_ovr = (k == ovr_k) && (k >= 2) && (k <= 530);
         check($sformatf("out_k%0d", k), 32'(obs), 32'(model(k)));
         check($sformatf("ovr_k%0d", k), 32'(bus.overrun), 32'(exp_ovr));
         prev_ovr = exp_ovr;
         if (bus.band_done) begin
            check($sformatf("bd_band%0d", bd_cnt), 32'(bus.band_sel), 32'(bd_cnt));
            bd_cnt++;
            band_total++;
         end
      end
      if (last_k >= 530) check("band_done_cnt", 32'(bd_cnt), 32'd8);
   endtask

   task automatic async_reset(input string tag);
      #3;
      rst = 1'b1;
      #1;
      check({tag, "_outs"}, 32'(obs), 32'd0);
      check({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
      step();
      #2;
      rst = 1'b0;
      step();
      check({tag, "_idle"}, 32'(obs), 32'd0);
   endtask

   initial begin
      bus.clk_enable   = 1'b1;
      bus.sample_valid = 1'b0;
      rst = 1'b1;
      repeat (10) step();
      check("rst_busy",     32'(bus.busy),       32'd0);
      check("rst_band_sel", 32'(bus.band_sel),   32'd0);
      check("rst_tap_addr", 32'(bus.tap_addr),   32'd0);
      check("rst_clear",    32'(bus.mac_clear),  32'd0);
      check("rst_en",       32'(bus.mac_en),     32'd0);
      check("rst_bdone",    32'(bus.band_done),  32'd0);
      check("rst_fdone",    32'(bus.frame_done), 32'd0);
      check("rst_ovr",      32'(bus.overrun),    32'd0);
      rst = 1'b0;
      step();

      // Async reset between edges, a few cycles into a frame
      run_frame(1'b0, 0, 5);
      async_reset("arst_early");

      // Single ungated frame through to idle
      run_frame(1'b0, 0, 530);
      step();
      check("post_frame_idle", 32'(obs), 32'd0);

      // Enable toggled every cycle
      run_frame(1'b1, 0, 530);
      step();

      // Overrun at band 3 / tap 10, then coincident with the DONE->IDLE edge
      run_frame(1'b0, 211, 530);
      step();
      run_frame(1'b0, 530, 531);
      step();
      check("no_restart", 32'(obs), 32'd0);

      // Reset at band 5 / tap 40, then a clean frame
      run_frame(1'b0, 0, 372);
      check("pre_rst_band", 32'(bus.band_sel), 32'd5);
      check("pre_rst_tap",  32'(bus.tap_addr), 32'd40);
      async_reset("arst_mid");
      run_frame(1'b0, 0, 530);

      // Back-to-back: each capture lands one enabled cycle after DONE->IDLE
      band_total = 0;
      run_frame(1'b0, 0, 530);
      run_frame(1'b0, 0, 530);
      run_frame(1'b0, 0, 530);
      check("b2b_band_total", 32'(band_total), 32'd24);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
